uart_tx_fifo: RTL and testbench

- Parametrised successor to the team's basic UART transmitter.
- Adds:
  - configurable data width
  - runtime-selectable parity (none/even/odd) and stop-bit count
  - an internal programmable baud divider, replacing the external baud strobe
  - a ready/valid input interface backed by a small FIFO, so software can queue words and frames go out back-to-back with no idle gap.
- Sits between the bus/register interface and the serial pin.

---
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a ready/valid input FIFO, internal baud divider,
// runtime-selectable parity and stop-bit count; back-to-back frames are gapless.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   push;
  logic                   pop;
  logic                   fifo_empty;
  logic                   bit_end;
  logic                   frame_end;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [BW-1:0]          bit_idx;
  logic                   par_en;
  logic                   par_bit;
  logic                   two_stop_q;
  logic                   stop_second;

  assign s_ready    = (fifo_count != FULL);
  assign fifo_empty = (fifo_count == '0);
  assign push       = s_valid && s_ready;
  assign bit_end    = (div_cnt == div_q - DIV_WIDTH'(1));
  assign frame_end  = (state == STOP) && bit_end && (!two_stop_q || stop_second);
  assign pop        = !fifo_empty && ((state == IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_serial   <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      div_q       <= DIV_WIDTH'(1);
      div_cnt     <= '0;
      shreg       <= '0;
      bit_idx     <= '0;
      par_en      <= 1'b0;
      par_bit     <= 1'b0;
      two_stop_q  <= 1'b0;
      stop_second <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE) div_cnt <= bit_end ? '0 : div_cnt + DIV_WIDTH'(1);

      case (state)
        IDLE: tx_serial <= 1'b1;
        START: begin
          if (bit_end) begin
            state     <= DATA;
            tx_serial <= shreg[0];
            shreg     <= shreg >> 1;
            bit_idx   <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_BIT) begin
              stop_second <= 1'b0;
              if (par_en) begin
                state     <= PARITY;
                tx_serial <= par_bit;
              end else begin
                state     <= STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + BW'(1);
              tx_serial <= shreg[0];
              shreg     <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state     <= STOP;
            tx_serial <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (frame_end) begin
              tx_done   <= 1'b1;
              state     <= IDLE;
              tx_busy   <= 1'b0;
              tx_serial <= 1'b1;
            end else begin
              stop_second <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A pop (from IDLE or the last stop cycle) overrides the case above,
      // which is what makes back-to-back frames start with no idle cycle.
      if (pop) begin
        state       <= START;
        tx_serial   <= 1'b0;
        tx_busy     <= 1'b1;
        div_cnt     <= '0;
        shreg       <= mem[rd_ptr];
        div_q       <= (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
        par_en      <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
        par_bit     <= (^mem[rd_ptr]) ^ (parity_mode == 2'd2);
        two_stop_q  <= two_stop;
        stop_second <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a scoreboard-fed line monitor plus
// table-driven frame vectors and hand-written FIFO/reset/divider sequences.
module tb_uart_tx_fifo;

  localparam int DW  = 8;
  localparam int FD  = 4;
  localparam int DVW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DW-1:0]   s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DVW-1:0]  baud_div = 16'd4;
  logic [1:0]      parity_mode = 2'd0;
  logic            two_stop = 1'b0;
  logic            tx_serial;
  logic            tx_busy;
  logic            tx_done;
  logic [$clog2(FD):0] fifo_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .DIV_WIDTH(DVW)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .tx_serial(tx_serial), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [1:0] pmode;
    logic       two_stop;
  } frame_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  pmode;
    logic        two_stop;
    int          exp_len;
    int          exp_nbits;
    logic [15:0] exp_cap;
  } vec_t;

  frame_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] d);
    frame_t f;
    f.data     = d;
    f.div      = (baud_div == 0) ? 1 : int'(baud_div);
    f.pmode    = parity_mode;
    f.two_stop = two_stop;
    return f;
  endfunction

  // Line monitor: expected waveform is built from the scoreboard entry.
  logic        rst_q = 1'b1;
  logic        in_frame = 1'b0;
  logic        expect_done = 1'b0;
  int          cyc, total, nbits, div_m, bi;
  logic [15:0] exp_bits, cap, last_cap;
  int          last_len = 0;
  int          last_nbits = 0;
  int          done_count = 0;
  frame_t      m_e;

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_serial", tx_serial, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_count", fifo_count, 0);
      sb.delete();
      in_frame    = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (tx_done === 1'b1) done_count++;
      if (expect_done) begin
        chk("tx_done_pulse", tx_done, 1);
        expect_done = 1'b0;
      end else begin
        chk("tx_done_spurious", tx_done, 0);
      end
      if (!in_frame && tx_serial === 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_start", tx_serial, 1);
        end else begin
          m_e      = sb.pop_front();
          div_m    = m_e.div;
          exp_bits = '0;
          for (int i = 0; i < DW; i++) exp_bits[1 + i] = m_e.data[i];
          nbits = 1 + DW;
          if (m_e.pmode == 2'd1 || m_e.pmode == 2'd2) begin
            exp_bits[nbits] = (^m_e.data) ^ (m_e.pmode == 2'd2);
            nbits++;
          end
          exp_bits[nbits] = 1'b1;
          nbits++;
          if (m_e.two_stop) begin
            exp_bits[nbits] = 1'b1;
            nbits++;
          end
          total    = nbits * div_m;
          cyc      = 0;
          cap      = '0;
          in_frame = 1'b1;
        end
      end
      if (in_frame) begin
        bi = cyc / div_m;
        if (cyc % div_m == 0) cap[bi] = tx_serial;
        chk("serial_bit", tx_serial, exp_bits[bi]);
        chk("busy_in_frame", tx_busy, 1);
        cyc++;
        if (cyc == total) begin
          in_frame    = 1'b0;
          expect_done = 1'b1;
          last_len    = cyc;
          last_cap    = cap;
          last_nbits  = nbits;
        end
      end else if (rst_q === 1'b0) begin
        chk("busy_idle", tx_busy, 0);
      end
    end
  end

  logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  task automatic push_word(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("push_timeout", s_ready, 1);
    @(posedge clk);
    sb.push_back(mk(d));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int start = done_count;
    int c = 0;
    while (done_count < start + n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (done_count < start + n) chk("done_timeout", done_count - start, n);
  endtask

  task automatic burst(input int nwords, input int ncycles, output int acc);
    int k = 0;
    acc = 0;
    @(negedge clk);
    for (int c = 0; c < ncycles; c++) begin
      if (k < nwords) begin
        s_data  = words[k];
        s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      if (s_valid && s_ready) begin
        @(posedge clk);
        sb.push_back(mk(words[k]));
        k++;
        acc++;
      end else begin
        @(posedge clk);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    baud_div    = v.div;
    parity_mode = v.pmode;
    two_stop    = v.two_stop;
    push_word(v.data);
    chk("lat_pre_serial", tx_serial, 1);
    chk("lat_pre_count", fifo_count, 1);
    @(negedge clk);
    chk("lat_start_serial", tx_serial, 0);
    chk("lat_start_busy", tx_busy, 1);
    chk("lat_start_count", fifo_count, 0);
    wait_done(1, 2000);
    chk("frame_len", last_len, v.exp_len);
    chk("frame_nbits", last_nbits, v.exp_nbits);
    chk("frame_bits", last_cap, v.exp_cap);
    @(negedge clk);
    chk("post_busy", tx_busy, 0);
    chk("post_sb_empty", sb.size(), 0);
  endtask

  vec_t vecs[6];
  int   acc;
  int   d0;

  initial begin
    vecs[0] = '{8'hA5, 16'd4, 2'd0, 1'b0, 40, 10, 16'h034A};
    vecs[1] = '{8'h07, 16'd2, 2'd1, 1'b0, 22, 11, 16'h060E};
    vecs[2] = '{8'h07, 16'd2, 2'd2, 1'b0, 22, 11, 16'h040E};
    vecs[3] = '{8'h00, 16'd3, 2'd1, 1'b1, 36, 12, 16'h0C00};
    vecs[4] = '{8'h3C, 16'd0, 2'd0, 1'b0, 10, 10, 16'h0278};
    vecs[5] = '{8'hA5, 16'd1, 2'd3, 1'b0, 10, 10, 16'h034A};

    repeat (3) @(negedge clk);
    chk("reset_serial", tx_serial, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_ready", s_ready, 1);
    chk("reset_count", fifo_count, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // FIFO fill with s_valid held: 5 accepted, then full.
    baud_div    = 16'd100;
    parity_mode = 2'd0;
    two_stop    = 1'b0;
    d0 = done_count;
    burst(6, 12, acc);
    chk("burst_accepted", acc, 5);
    chk("burst_count", fifo_count, 4);
    chk("burst_ready", s_ready, 0);
    wait_done(5, 6000);
    chk("burst_done_pulses", done_count - d0, 5);
    @(negedge clk);
    chk("burst_post_busy", tx_busy, 0);
    chk("burst_sb_empty", sb.size(), 0);

    // Reset mid-frame during DATA of the second queued word.
    baud_div = 16'd10;
    burst(3, 4, acc);
    chk("abort_accepted", acc, 3);
    wait_done(1, 300);
    repeat (25) @(negedge clk);
    d0 = done_count;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_serial", tx_serial, 1);
    chk("abort_count", fifo_count, 0);
    chk("abort_busy", tx_busy, 0);
    chk("abort_ready", s_ready, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_done", tx_done, 0);
    chk("abort_idle_serial", tx_serial, 1);
    chk("abort_idle_busy", tx_busy, 0);
    chk("abort_done_count", done_count - d0, 0);
    run_vec('{8'h5A, 16'd10, 2'd0, 1'b0, 100, 10, 16'h02B4});

    // Divider change mid-frame must not affect the frame in flight.
    baud_div = 16'd0;
    push_word(8'h3C);
    repeat (3) @(negedge clk);
    baud_div = 16'd7;
    wait_done(1, 200);
    chk("middiv_len", last_len, 10);
    chk("middiv_bits", last_cap, 16'h0278);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
